jtag_mem_arbiter: RTL and testbench

Shares the single 64-bit debug/boot memory port between two requesters.
- Master A is the JTAG loader/address-register path.
- Master B is the core-side (or second JTAG chain) requester.
- During boot initialisation (init_i=1), A owns the port exclusively.
- Otherwise A has fixed priority, and a starvation counter guarantees B forward progress.
- Replaces the ad-hoc INIT address/write-enable mux in front of the memory with a proper grant/response handshake.

---
 rtl/jtag_mem_arbiter_if.sv | 50 +++++
 rtl/jtag_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_jtag_mem_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_mem_arbiter_if.sv
// rtl/jtag_mem_arbiter_if.sv - request/grant/response bundle between masters A/B, the arbiter and the memory port
//
// Signals (named from the arbiter's point of view):
//   a_*/b_* : req/we/addr/wdata in, gnt/rvalid/rdata out, one set per master
//   mem_*   : en/we/addr/wdata out to the memory, rdata back (valid 1 cycle after en)
// Modports: slave = arbiter side, master = requesters + memory model side.
interface jtag_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              a_req_i;
    logic              a_we_i;
    logic [ADDR_W-1:0] a_addr_i;
    logic [DATA_W-1:0] a_wdata_i;
    logic              a_gnt_o;
    logic              a_rvalid_o;
    logic [DATA_W-1:0] a_rdata_o;

    logic              b_req_i;
    logic              b_we_i;
    logic [ADDR_W-1:0] b_addr_i;
    logic [DATA_W-1:0] b_wdata_i;
    logic              b_gnt_o;
    logic              b_rvalid_o;
    logic [DATA_W-1:0] b_rdata_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  a_req_i, a_we_i, a_addr_i, a_wdata_i,
        output a_gnt_o, a_rvalid_o, a_rdata_o,
        input  b_req_i, b_we_i, b_addr_i, b_wdata_i,
        output b_gnt_o, b_rvalid_o, b_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output a_req_i, a_we_i, a_addr_i, a_wdata_i,
        input  a_gnt_o, a_rvalid_o, a_rdata_o,
        output b_req_i, b_we_i, b_addr_i, b_wdata_i,
        input  b_gnt_o, b_rvalid_o, b_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/jtag_mem_arbiter.sv
// rtl/jtag_mem_arbiter.sv - two-master arbiter for the 64-bit debug/boot memory port
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   init_i        : boot-init mode, A owns the port exclusively and no address offset is applied
//   bus           : jtag_mem_arbiter_if.slave (masters A/B and memory port)
//   stat_a_o, stat_b_o, stat_conflict_o : access/conflict counters, present only with ARB_STATS_EN
//
// Optional feature macro: ARB_STATS_EN
module jtag_mem_arbiter #(
    parameter int                ADDR_W        = 32,
    parameter int                DATA_W        = 64,
    parameter logic [ADDR_W-1:0] A_ADDR_OFFSET = 'h0080_0000,
    parameter int                STARVE_LIMIT  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   init_i,
    jtag_mem_arbiter_if.slave      bus
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]            stat_a_o,
    output logic [31:0]            stat_b_o,
    output logic [31:0]            stat_conflict_o
`endif
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        MODE_ARB  = 1'b0,
        MODE_INIT = 1'b1
    } mode_t;

    mode_t      mode_q, mode_d;
    logic [3:0] starve_q, starve_d;
    logic       gnt_a_raw, gnt_b_raw;
    logic       gnt_a, gnt_b;
    logic       init_edge;

    logic       rsp_valid_q;
    logic       rsp_owner_q;   // 1 = response belongs to B
    logic       rsp_we_q;

    // Mode follows init_i combinationally; the register only detects edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q   <= MODE_ARB;
            starve_q <= 4'd0;
        end else begin
            mode_q   <= mode_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        mode_d    = init_i ? MODE_INIT : MODE_ARB;
        init_edge = (mode_d != mode_q);
        gnt_a_raw = 1'b0;
        gnt_b_raw = 1'b0;
        starve_d  = starve_q;

        if (mode_d == MODE_INIT) begin
            gnt_a_raw = bus.a_req_i;
        end else if (bus.a_req_i && bus.b_req_i) begin
            if (starve_q == LIMIT) gnt_b_raw = 1'b1;
            else                   gnt_a_raw = 1'b1;
        end else begin
            gnt_a_raw = bus.a_req_i;
            gnt_b_raw = bus.b_req_i;
        end

        // In ARB mode, A granted while B requests is a contended A win.
        if ((mode_d == MODE_INIT) || init_edge || gnt_b_raw || !bus.b_req_i) begin
            starve_d = 4'd0;
        end else if (gnt_a_raw && (starve_q != LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Grants are combinational from req, so they are forced low while reset is held.
    assign gnt_a = gnt_a_raw & rst_ni;
    assign gnt_b = gnt_b_raw & rst_ni;

    assign bus.a_gnt_o     = gnt_a;
    assign bus.b_gnt_o     = gnt_b;
    assign bus.mem_en_o    = gnt_a | gnt_b;
    assign bus.mem_we_o    = gnt_a ? bus.a_we_i : (gnt_b ? bus.b_we_i : 1'b0);
    assign bus.mem_addr_o  = gnt_a ? (init_i ? bus.a_addr_i : (bus.a_addr_i | A_ADDR_OFFSET))
                           : (gnt_b ? bus.b_addr_i : '0);
    assign bus.mem_wdata_o = gnt_a ? bus.a_wdata_i : (gnt_b ? bus.b_wdata_i : '0);

    // One-stage response tag: owner is captured at grant time so an init_i
    // change never redirects an in-flight response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_we_q    <= 1'b0;
        end else begin
            rsp_valid_q <= gnt_a | gnt_b;
            rsp_owner_q <= gnt_b;
            rsp_we_q    <= bus.mem_we_o;
        end
    end

    assign bus.a_rvalid_o = rsp_valid_q & ~rsp_owner_q;
    assign bus.b_rvalid_o = rsp_valid_q &  rsp_owner_q;
    assign bus.a_rdata_o  = (bus.a_rvalid_o && !rsp_we_q) ? bus.mem_rdata_i : '0;
    assign bus.b_rdata_o  = (bus.b_rvalid_o && !rsp_we_q) ? bus.mem_rdata_i : '0;

`ifdef ARB_STATS_EN
    logic init_rise;
    assign init_rise = init_i && (mode_q == MODE_ARB);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_a_o        <= 32'd0;
            stat_b_o        <= 32'd0;
            stat_conflict_o <= 32'd0;
        end else if (init_rise) begin
            stat_a_o        <= 32'd0;
            stat_b_o        <= 32'd0;
            stat_conflict_o <= 32'd0;
        end else begin
            if (gnt_a)                       stat_a_o        <= stat_a_o + 32'd1;
            if (gnt_b)                       stat_b_o        <= stat_b_o + 32'd1;
            if (bus.a_req_i && bus.b_req_i)  stat_conflict_o <= stat_conflict_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_jtag_mem_arbiter.sv
// tb/tb_jtag_mem_arbiter.sv - self-checking bench for jtag_mem_arbiter
module tb_jtag_mem_arbiter;
    localparam logic [31:0] OFFSET = 32'h0080_0000;
    localparam int          LIMIT  = 4;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic init_i = 1'b0;
    always #5 clk = ~clk;

    jtag_mem_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

`ifdef ARB_STATS_EN
    logic [31:0] stat_a, stat_b, stat_c;
`endif

    jtag_mem_arbiter #(
        .ADDR_W(32), .DATA_W(64), .A_ADDR_OFFSET(OFFSET), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .init_i (init_i),
        .bus    (bus)
`ifdef ARB_STATS_EN
        ,
        .stat_a_o        (stat_a),
        .stat_b_o        (stat_b),
        .stat_conflict_o (stat_c)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_pv, m_po, m_pw;   // pending response: valid, owner is B, was a write
    int          m_streak;           // consecutive contended A wins
    bit          m_prev_init;
    int unsigned m_sa, m_sb, m_sc;
    bit          last_ga, last_gb;
    logic [9:0]  gnt_log;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pv = 0; m_po = 0; m_pw = 0;
        m_streak = 0; m_prev_init = 0;
        m_sa = 0; m_sb = 0; m_sc = 0;
        last_ga = 0; last_gb = 0;
    endtask

    // One clock: check everything at the falling edge, advance the model,
    // then return 1 time unit after the rising edge.
    task automatic step();
        bit          ea, eb, ewe, era, erb;
        logic [31:0] eaddr;
        logic [63:0] ewd;
        @(negedge clk);
        ea = 0; eb = 0;
        if (init_i) begin
            ea = bus.a_req_i;
        end else if (bus.a_req_i && bus.b_req_i) begin
            if (m_streak >= LIMIT) eb = 1; else ea = 1;
        end else begin
            ea = bus.a_req_i;
            eb = bus.b_req_i;
        end
        ewe   = ea ? bus.a_we_i : (eb ? bus.b_we_i : 1'b0);
        eaddr = ea ? (init_i ? bus.a_addr_i : (bus.a_addr_i | OFFSET)) : (eb ? bus.b_addr_i : 32'd0);
        ewd   = ea ? bus.a_wdata_i : (eb ? bus.b_wdata_i : 64'd0);
        era   = m_pv && !m_po;
        erb   = m_pv && m_po;

        chk("a_gnt", bus.a_gnt_o, ea);
        chk("b_gnt", bus.b_gnt_o, eb);
        chk("mem_en", bus.mem_en_o, ea | eb);
        chk("mem_we", bus.mem_we_o, ewe);
        chk("mem_addr", bus.mem_addr_o, eaddr);
        chk("mem_wdata", bus.mem_wdata_o, ewd);
        chk("a_rvalid", bus.a_rvalid_o, era);
        chk("b_rvalid", bus.b_rvalid_o, erb);
        chk("a_rdata", bus.a_rdata_o, (era && !m_pw) ? bus.mem_rdata_i : 64'd0);
        chk("b_rdata", bus.b_rdata_o, (erb && !m_pw) ? bus.mem_rdata_i : 64'd0);
`ifdef ARB_STATS_EN
        chk("stat_a", stat_a, m_sa);
        chk("stat_b", stat_b, m_sb);
        chk("stat_conflict", stat_c, m_sc);
`endif
        gnt_log = {gnt_log[8:0], bus.b_gnt_o};

        if (init_i && !m_prev_init) begin
            m_sa = 0; m_sb = 0; m_sc = 0;
        end else begin
            m_sa += ea;
            m_sb += eb;
            if (bus.a_req_i && bus.b_req_i) m_sc++;
        end
        if (init_i || (init_i != m_prev_init) || eb || !bus.b_req_i) m_streak = 0;
        else if (ea && m_streak < LIMIT) m_streak++;
        m_pv = ea | eb;
        m_po = eb;
        m_pw = ewe;
        m_prev_init = init_i;
        last_ga = ea;
        last_gb = eb;
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input bit req, input bit we, input logic [31:0] addr, input logic [63:0] wd);
        bus.a_req_i = req; bus.a_we_i = we; bus.a_addr_i = addr; bus.a_wdata_i = wd;
    endtask

    task automatic set_b(input bit req, input bit we, input logic [31:0] addr, input logic [63:0] wd);
        bus.b_req_i = req; bus.b_we_i = we; bus.b_addr_i = addr; bus.b_wdata_i = wd;
    endtask

    initial begin
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        bus.mem_rdata_i = 64'h0;
        gnt_log = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_gnt", bus.a_gnt_o, 0);
        chk("rst_mem_en", bus.mem_en_o, 0);
        chk("rst_b_rvalid", bus.b_rvalid_o, 0);
        rst_ni = 1'b1;

        // INIT exclusive: A read 0x10 while B also requests
        init_i = 1'b1;
        set_a(1, 0, 32'h10, 64'h0);
        set_b(1, 0, 32'h44, 64'h0);
        bus.mem_rdata_i = 64'h1122_3344_5566_7788;
        step();
        chk("init_mem_addr", bus.mem_addr_o, 32'h10);
        chk("init_b_gnt", bus.b_gnt_o, 0);
        chk("init_a_rvalid", bus.a_rvalid_o, 1);
        chk("init_a_rdata", bus.a_rdata_o, 64'h1122_3344_5566_7788);
        for (int i = 0; i < 19; i++) begin
            bus.mem_rdata_i = {$urandom, $urandom};
            step();
        end

        // Offset: A write outside init
        init_i = 1'b0;
        set_b(0, 0, 0, 0);
        set_a(1, 1, 32'h20, 64'hDEAD_BEEF_0000_0001);
        step();
        chk("ofs_mem_addr", bus.mem_addr_o, 32'h0080_0020);
        chk("ofs_mem_we", bus.mem_we_o, 1);
        chk("ofs_a_rvalid", bus.a_rvalid_o, 1);
        chk("ofs_a_rdata", bus.a_rdata_o, 64'h0);

        // Starvation pattern (and stats from a cleared state)
        set_a(0, 0, 0, 0);
        step();
        init_i = 1'b1;
        step();
        init_i = 1'b0;
        step();
        set_a(1, 0, 32'h100, 64'h0);
        set_b(1, 0, 32'h200, 64'h0);
        for (int i = 0; i < 10; i++) begin
            bus.mem_rdata_i = {$urandom, $urandom};
            step();
        end
        chk("starve_pattern", gnt_log, 10'b00001_00001);
`ifdef ARB_STATS_EN
        chk("stats_a_10", stat_a, 8);
        chk("stats_b_10", stat_b, 2);
        chk("stats_c_10", stat_c, 10);
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        init_i = 1'b1;
        step();
        chk("stats_clr_a", stat_a, 0);
        chk("stats_clr_b", stat_b, 0);
        chk("stats_clr_c", stat_c, 0);
        init_i = 1'b0;
        step();
`endif

        // Init edge while a B read is in flight
        set_a(0, 0, 0, 0);
        set_b(1, 0, 32'h88, 64'h0);
        step();
        init_i = 1'b1;
        bus.mem_rdata_i = 64'hCAFE_F00D_1234_5678;
        #1;
        chk("edge_b_rvalid", bus.b_rvalid_o, 1);
        chk("edge_b_rdata", bus.b_rdata_o, 64'hCAFE_F00D_1234_5678);
        chk("edge_b_gnt", bus.b_gnt_o, 0);
        step();
        step();

        // Asynchronous reset with a read pending
        init_i = 1'b0;
        set_b(0, 0, 0, 0);
        set_a(1, 0, 32'h30, 64'h0);
        step();
        #1 rst_ni = 1'b0;
        #1;
        chk("arst_a_rvalid", bus.a_rvalid_o, 0);
        chk("arst_a_gnt", bus.a_gnt_o, 0);
        chk("arst_mem_en", bus.mem_en_o, 0);
        chk("arst_mem_addr", bus.mem_addr_o, 0);
        chk("arst_a_rdata", bus.a_rdata_o, 0);
        set_a(0, 0, 0, 0);
        #1 rst_ni = 1'b1;
        model_reset();
        step();

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (!bus.a_req_i || last_ga)
                set_a($urandom_range(0, 2) != 0, 1'($urandom), $urandom, {$urandom, $urandom});
            if (!bus.b_req_i || last_gb)
                set_b($urandom_range(0, 3) != 0, 1'($urandom), $urandom, {$urandom, $urandom});
            if ($urandom_range(0, 24) == 0) init_i = ~init_i;
            bus.mem_rdata_i = {$urandom, $urandom};
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
